mem_port_arbiter: RTL and testbench

Shares one generic_memory access port (async read, sync write) between two requesters: port 0 = instruction fetch, port 1 = load/store unit. Each port has a valid/ready request channel and a valid/ready response channel. Round-robin arbitration, one access per cycle, registered response with backpressure. Sits between the fetch/LSU stages and the memory instance.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of one async-read/sync-write memory port.
// It holds one registered response, and a new access can issue in the same cycle that the held one drains.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_req_valid_i,
  output logic              p0_req_ready_o,
  input  logic              p0_req_we_i,
  input  logic [2:0]        p0_req_funct3_i,
  input  logic [ADDR_W-1:0] p0_req_addr_i,
  input  logic [DATA_W-1:0] p0_req_wdata_i,
  output logic              p0_resp_valid_o,
  input  logic              p0_resp_ready_i,
  output logic [DATA_W-1:0] p0_resp_rdata_o,
  output logic              p0_resp_error_o,

  input  logic              p1_req_valid_i,
  output logic              p1_req_ready_o,
  input  logic              p1_req_we_i,
  input  logic [2:0]        p1_req_funct3_i,
  input  logic [ADDR_W-1:0] p1_req_addr_i,
  input  logic [DATA_W-1:0] p1_req_wdata_i,
  output logic              p1_resp_valid_o,
  input  logic              p1_resp_ready_i,
  output logic [DATA_W-1:0] p1_resp_rdata_o,
  output logic              p1_resp_error_o,

  output logic [2:0]        mem_funct3_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_wr_en_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic [1:0]        mem_error_i
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e              state_q;
  logic                owner_q;
  logic                rr_ptr_q;
  logic                p0_vld_q;
  logic                p1_vld_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                owner_ready;
  logic                can_issue;
  logic                elig0;
  logic                elig1;
  logic                gnt0;
  logic                gnt1;
  logic                gnt_we;

  always_comb begin
    owner_ready = owner_q ? p1_resp_ready_i : p0_resp_ready_i;
    // A held response must drain before the single response register can take another.
    can_issue   = ~rst_i & ((state_q == StIdle) | owner_ready);
    elig0       = p0_req_valid_i & can_issue;
    elig1       = p1_req_valid_i & can_issue;
    gnt0        = elig0 & (~elig1 | ~rr_ptr_q);
    gnt1        = elig1 & (~elig0 | rr_ptr_q);
    gnt_we      = 1'b0;

    mem_funct3_o  = '0;
    mem_rd_addr_o = '0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    mem_wr_en_o   = 1'b0;
    if (gnt0) begin
      gnt_we        = p0_req_we_i;
      mem_funct3_o  = p0_req_funct3_i;
      mem_rd_addr_o = p0_req_addr_i;
      mem_wr_addr_o = p0_req_addr_i;
      mem_wr_data_o = p0_req_wdata_i;
      mem_wr_en_o   = p0_req_we_i;
    end else if (gnt1) begin
      gnt_we        = p1_req_we_i;
      mem_funct3_o  = p1_req_funct3_i;
      mem_rd_addr_o = p1_req_addr_i;
      mem_wr_addr_o = p1_req_addr_i;
      mem_wr_data_o = p1_req_wdata_i;
      mem_wr_en_o   = p1_req_we_i;
    end
  end

  assign p0_req_ready_o  = gnt0;
  assign p1_req_ready_o  = gnt1;
  assign p0_resp_valid_o = p0_vld_q;
  assign p1_resp_valid_o = p1_vld_q;
  assign p0_resp_rdata_o = rdata_q;
  assign p1_resp_rdata_o = rdata_q;
  assign p0_resp_error_o = err_q;
  assign p1_resp_error_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (gnt0 | gnt1) begin
      state_q  <= StHold;
      owner_q  <= gnt1;
      rr_ptr_q <= ~gnt1;
      p0_vld_q <= gnt0;
      p1_vld_q <= gnt1;
      rdata_q  <= gnt_we ? '0 : mem_rd_data_i;
      err_q    <= gnt_we ? mem_error_i[1] : mem_error_i[0];
    end else if ((state_q == StHold) && owner_ready) begin
      state_q  <= StIdle;
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural byte memory behind the port.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid, p0_resp_ready, p0_resp_error;
  logic [2:0]    p0_req_funct3;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_resp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid, p1_resp_ready, p1_resp_error;
  logic [2:0]    p1_req_funct3;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_resp_rdata;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          mem_wr_en;
  logic [1:0]    mem_error;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_valid_i(p0_req_valid), .p0_req_ready_o(p0_req_ready), .p0_req_we_i(p0_req_we),
    .p0_req_funct3_i(p0_req_funct3), .p0_req_addr_i(p0_req_addr),
    .p0_req_wdata_i(p0_req_wdata), .p0_resp_valid_o(p0_resp_valid),
    .p0_resp_ready_i(p0_resp_ready), .p0_resp_rdata_o(p0_resp_rdata),
    .p0_resp_error_o(p0_resp_error),
    .p1_req_valid_i(p1_req_valid), .p1_req_ready_o(p1_req_ready), .p1_req_we_i(p1_req_we),
    .p1_req_funct3_i(p1_req_funct3), .p1_req_addr_i(p1_req_addr),
    .p1_req_wdata_i(p1_req_wdata), .p1_resp_valid_o(p1_resp_valid),
    .p1_resp_ready_i(p1_resp_ready), .p1_resp_rdata_o(p1_resp_rdata),
    .p1_resp_error_o(p1_resp_error),
    .mem_funct3_o(mem_funct3), .mem_rd_addr_o(mem_rd_addr), .mem_wr_addr_o(mem_wr_addr),
    .mem_wr_data_o(mem_wr_data), .mem_wr_en_o(mem_wr_en), .mem_rd_data_i(mem_rd_data),
    .mem_error_i(mem_error)
  );

  // Memory model: size from funct3[1:0], loads always sign-extended, misaligned writes dropped.
  logic [7:0]  mem [0:(1<<AW)-1];
  logic [1:0]  msz;
  logic [63:0] raw;
  logic        unused_f3;
  assign unused_f3 = mem_funct3[2];

  function automatic logic misal(input logic [AW-1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    misal = 1'b0;
      2'd1:    misal = a[0];
      2'd2:    misal = |a[1:0];
      default: misal = |a[2:0];
    endcase
  endfunction

  always_comb begin
    msz = mem_funct3[1:0];
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[mem_rd_addr + AW'(i)];
    case (msz)
      2'd0:    mem_rd_data = {{56{raw[7]}}, raw[7:0]};
      2'd1:    mem_rd_data = {{48{raw[15]}}, raw[15:0]};
      2'd2:    mem_rd_data = {{32{raw[31]}}, raw[31:0]};
      default: mem_rd_data = raw;
    endcase
    mem_error = {misal(mem_wr_addr, msz), misal(mem_rd_addr, msz)};
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++) mem[pre_addr + AW'(i)] <= pre_data[8*i +: 8];
    end else if (mem_wr_en && !mem_error[1]) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << msz)) mem[mem_wr_addr + AW'(i)] <= mem_wr_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    pre_we = 1'b1; pre_addr = AW'(16'h0010); pre_data = 32'hDEADBEEF;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_funct3 = 3'b010;
    p0_req_addr = AW'(16'h0040); p0_req_wdata = '0; p0_resp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_funct3 = 3'b010;
    p1_req_addr = AW'(16'h0044); p1_req_wdata = '0; p1_resp_ready = 1'b1;

    // Reset held for two cycles with both ports requesting
    tick();
    pre_we = 1'b0;
    settle();
    chk("rst_p0_ready", 64'(p0_req_ready), 64'd0);
    chk("rst_p1_ready", 64'(p1_req_ready), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_p0_valid", 64'(p0_resp_valid), 64'd0);
    tick();
    rst = 1'b0;
    chk("rst_p1_valid", 64'(p1_resp_valid), 64'd0);
    chk("rst_p0_rdata", p0_resp_rdata, 64'd0);

    // Contention: grants alternate starting with port 0
    settle();
    chk("c0_p0_ready", 64'(p0_req_ready), 64'd1);
    chk("c0_p1_ready", 64'(p1_req_ready), 64'd0);
    chk("c0_addr", 64'(mem_rd_addr), 64'h40);
    tick();
    chk("c0_p0_valid", 64'(p0_resp_valid), 64'd1);
    settle();
    chk("c1_p1_ready", 64'(p1_req_ready), 64'd1);
    chk("c1_p0_ready", 64'(p0_req_ready), 64'd0);
    chk("c1_addr", 64'(mem_rd_addr), 64'h44);
    tick();
    chk("c1_p1_valid", 64'(p1_resp_valid), 64'd1);
    chk("c1_p0_valid", 64'(p0_resp_valid), 64'd0);
    settle();
    chk("c2_p0_ready", 64'(p0_req_ready), 64'd1);
    chk("c2_addr", 64'(mem_rd_addr), 64'h40);
    tick();
    chk("c2_p0_valid", 64'(p0_resp_valid), 64'd1);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    settle();
    chk("idle_addr", 64'(mem_rd_addr), 64'd0);
    tick();
    chk("drain_p0_valid", 64'(p0_resp_valid), 64'd0);

    // Single load on port 1
    p1_req_valid = 1'b1; p1_req_funct3 = 3'b010; p1_req_addr = AW'(16'h0010);
    settle();
    chk("ld_p1_ready", 64'(p1_req_ready), 64'd1);
    tick();
    p1_req_valid = 1'b0;
    chk("ld_p1_valid", 64'(p1_resp_valid), 64'd1);
    chk("ld_p1_rdata", p1_resp_rdata, 64'hFFFFFFFFDEADBEEF);
    chk("ld_p1_error", 64'(p1_resp_error), 64'd0);
    chk("ld_p0_valid", 64'(p0_resp_valid), 64'd0);
    tick();
    chk("ld_drain", 64'(p1_resp_valid), 64'd0);

    // Backpressure from port 0 blocks port 1
    p0_req_valid = 1'b1; p0_req_funct3 = 3'b010; p0_req_addr = AW'(16'h0010);
    p0_resp_ready = 1'b0;
    settle();
    chk("bp_p0_ready", 64'(p0_req_ready), 64'd1);
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b1; p1_req_funct3 = 3'b010; p1_req_addr = AW'(16'h0014);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_p1_blocked", 64'(p1_req_ready), 64'd0);
      chk("bp_p0_valid", 64'(p0_resp_valid), 64'd1);
      chk("bp_p0_rdata", p0_resp_rdata, 64'hFFFFFFFFDEADBEEF);
      tick();
    end
    p0_resp_ready = 1'b1;
    settle();
    chk("bp_p1_ready", 64'(p1_req_ready), 64'd1);
    tick();
    p1_req_valid = 1'b0;
    chk("bp_p1_valid", 64'(p1_resp_valid), 64'd1);
    chk("bp_p0_valid_off", 64'(p0_resp_valid), 64'd0);
    tick();

    // Byte store then sign-extended byte load
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_funct3 = 3'b000;
    p1_req_addr = AW'(16'h0021); p1_req_wdata = 64'hA5;
    settle();
    chk("st_wr_en", 64'(mem_wr_en), 64'd1);
    chk("st_wr_addr", 64'(mem_wr_addr), 64'h21);
    tick();
    chk("st_valid", 64'(p1_resp_valid), 64'd1);
    chk("st_rdata", p1_resp_rdata, 64'd0);
    chk("st_error", 64'(p1_resp_error), 64'd0);
    p1_req_we = 1'b0; p1_req_funct3 = 3'b100;
    settle();
    chk("ld2_ready", 64'(p1_req_ready), 64'd1);
    tick();
    chk("ld2_valid", 64'(p1_resp_valid), 64'd1);
    chk("ld2_rdata", p1_resp_rdata, 64'hFFFFFFFFFFFFFFA5);

    // Misaligned store and load
    p1_req_we = 1'b1; p1_req_funct3 = 3'b010; p1_req_addr = AW'(16'h0002);
    p1_req_wdata = 64'h12345678;
    settle();
    chk("mis_st_wr_en", 64'(mem_wr_en), 64'd1);
    tick();
    p1_req_valid = 1'b0; p1_req_we = 1'b0;
    chk("mis_st_error", 64'(p1_resp_error), 64'd1);
    chk("mis_st_valid", 64'(p1_resp_valid), 64'd1);
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_funct3 = 3'b001; p0_req_addr = AW'(16'h0003);
    settle();
    chk("mis_ld_ready", 64'(p0_req_ready), 64'd1);
    tick();
    chk("mis_ld_error", 64'(p0_resp_error), 64'd1);
    chk("mis_ld_valid", 64'(p0_resp_valid), 64'd1);

    // Reset while a response is held
    p0_req_valid = 1'b0; p0_resp_ready = 1'b0;
    tick();
    chk("hold_p0_valid", 64'(p0_resp_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rsthold_p0_valid", 64'(p0_resp_valid), 64'd0);
    chk("rsthold_p1_valid", 64'(p1_resp_valid), 64'd0);
    rst = 1'b0;
    p0_resp_ready = 1'b1;
    tick();
    chk("post_rst_p0_valid", 64'(p0_resp_valid), 64'd0);
    p0_req_valid = 1'b1; p0_req_funct3 = 3'b010; p0_req_addr = AW'(16'h0040);
    p1_req_valid = 1'b1; p1_req_funct3 = 3'b010; p1_req_addr = AW'(16'h0044);
    settle();
    chk("post_rst_p0_first", 64'(p0_req_ready), 64'd1);
    chk("post_rst_p1_wait", 64'(p1_req_ready), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
